uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first: the receive-side counterpart of the team's `uart_tx` and the inbound path from the HM-10 BLE module. Samples the raw `rx` pin through a two-flop synchronizer, validates the start bit at mid-bit, and samples 8 data bits and the stop bit at their bit centres. Each good byte is presented with a one-cycle `valid` strobe; a bad stop bit produces a one-cycle `frame_err` strobe instead.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART: serial line in, byte and status strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output valid, output frame_err, output busy);
  modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop synchronizer, mid-bit start validation,
// centre-of-bit sampling, one-cycle valid / frame_err strobes, break lockout.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 32'd50_000_000,
  parameter int unsigned BAUD       = 32'd9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned BAUD_TICKS = CLOCK_FREQ / BAUD;
  localparam int unsigned HALF       = BAUD_TICKS / 32'd2;
  localparam int unsigned CW         = $clog2(BAUD_TICKS);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 32'd1);
  localparam logic [CW-1:0] TICK_M1  = CW'(BAUD_TICKS - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          s1_q, s2_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  assign rx_s = s2_q;

  // Next-state and output decode; strobes default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == TICK_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == TICK_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A held-low line must return high before another frame is accepted.
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= bus.rx;
      s2_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (HALF=8): timing, back-to-back,
// glitch, framing error/break, mid-frame reset and +/-2% baud skew.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   nvalid = 0;
  int   nerr = 0;
  int   nconsec = 0;
  int   vcyc = 0;
  int   start_cyc = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] vlog [0:31];
  logic [7:0] b2b [0:3];
  int   c0;

  uart_rx_if u_if ();

  uart_rx #(.CLOCK_FREQ(32'd16), .BAUD(32'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts pulses, logs received bytes, flags adjacent strobes.
  always @(negedge clk) begin
    if (u_if.valid) begin
      vlog[nvalid[4:0]] <= u_if.data;
      nvalid <= nvalid + 1;
      vcyc   <= cyc;
    end
    if (u_if.frame_err) nerr <= nerr + 1;
    if ((u_if.valid || u_if.frame_err) && prev_strobe) nconsec <= nconsec + 1;
    prev_strobe <= u_if.valid || u_if.frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame from the current negedge; p100 is the bit period in 1/100 clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p100);
    logic [9:0] fr;
    int n;
    fr = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      u_if.rx = fr[k];
      n = ((k + 1) * p100) / 100 - (k * p100) / 100;
      repeat (n) @(negedge clk);
    end
  endtask

  initial begin
    b2b[0] = 8'hA5; b2b[1] = 8'h00; b2b[2] = 8'hFF; b2b[3] = 8'h5A;
    u_if.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data", {24'd0, u_if.data}, 32'h00);
    check_eq("rst_valid", {31'd0, u_if.valid}, 32'd0);
    check_eq("rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, u_if.busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'h3C, 1'b1, 1600);
    repeat (20) @(negedge clk);
    check_eq("exact_count", nvalid, 32'd1);
    check_eq("exact_data", {24'd0, u_if.data}, 32'h3C);
    check_eq("exact_latency", vcyc - start_cyc, 32'd155);
    check_eq("exact_busy_idle", {31'd0, u_if.busy}, 32'd0);

    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, 1600);
    repeat (20) @(negedge clk);
    check_eq("b2b_count", nvalid, 32'd5);
    for (int i = 0; i < 4; i++) check_eq("b2b_data", {24'd0, vlog[1 + i]}, {24'd0, b2b[i]});
    check_eq("b2b_ferr", nerr, 32'd0);

    c0 = cyc;
    u_if.rx = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("glitch_busy_pre", {31'd0, u_if.busy}, 32'd0);
    @(negedge clk);
    u_if.rx = 1'b1;
    check_eq("glitch_busy_rise", {31'd0, u_if.busy}, 32'd1);
    repeat (7) @(negedge clk);
    check_eq("glitch_busy_hold", {31'd0, u_if.busy}, 32'd1);
    @(negedge clk);
    check_eq("glitch_busy_drop", {31'd0, u_if.busy}, 32'd0);
    check_eq("glitch_cycle", cyc - c0, 32'd11);
    repeat (30) @(negedge clk);
    check_eq("glitch_novalid", nvalid, 32'd5);
    check_eq("glitch_noferr", nerr, 32'd0);
    send_frame(8'h81, 1'b1, 1600);
    repeat (20) @(negedge clk);
    check_eq("glitch_next", {24'd0, u_if.data}, 32'h81);
    check_eq("glitch_next_count", nvalid, 32'd6);

    send_frame(8'h42, 1'b0, 1600);
    repeat (48) @(negedge clk);
    check_eq("ferr_count", nerr, 32'd1);
    check_eq("ferr_novalid", nvalid, 32'd6);
    check_eq("ferr_data_kept", {24'd0, u_if.data}, 32'h81);
    check_eq("ferr_busy_break", {31'd0, u_if.busy}, 32'd1);
    u_if.rx = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("ferr_busy_clear", {31'd0, u_if.busy}, 32'd0);
    send_frame(8'h42, 1'b1, 1600);
    repeat (20) @(negedge clk);
    check_eq("ferr_recover", {24'd0, u_if.data}, 32'h42);
    check_eq("ferr_recover_count", nvalid, 32'd7);

    // 0xC3: start, bits 0..3 (1,1,0,0), then half of bit 4 (0) before reset.
    u_if.rx = 1'b0; repeat (16) @(negedge clk);
    u_if.rx = 1'b1; repeat (32) @(negedge clk);
    u_if.rx = 1'b0; repeat (40) @(negedge clk);
    check_eq("mid_busy_pre", {31'd0, u_if.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_data", {24'd0, u_if.data}, 32'h00);
    check_eq("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    check_eq("mid_rst_valid", {30'd0, u_if.valid, u_if.frame_err}, 32'd0);
    @(negedge clk);
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("mid_nostrobe", nvalid + nerr, 32'd8);
    send_frame(8'h18, 1'b1, 1600);
    repeat (20) @(negedge clk);
    check_eq("mid_next", {24'd0, u_if.data}, 32'h18);
    check_eq("mid_next_count", nvalid, 32'd8);

    send_frame(8'h55, 1'b1, 1632);
    repeat (20) @(negedge clk);
    check_eq("skew_slow", {24'd0, u_if.data}, 32'h55);
    send_frame(8'hAA, 1'b1, 1568);
    repeat (20) @(negedge clk);
    check_eq("skew_fast", {24'd0, u_if.data}, 32'hAA);
    check_eq("skew_count", nvalid, 32'd10);
    check_eq("skew_ferr", nerr, 32'd1);
    check_eq("no_adjacent_strobes", nconsec, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
